// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci/Galois LFSR with seed load and period measurement
module lfsr_gen #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'h60,
    parameter logic [WIDTH-1:0] SEED  = 7'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             mode,
    output logic [WIDTH-1:0] data_out,
    output logic             bit_out,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] anchor;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] galois_poly;
    logic [WIDTH-1:0] load_val;
    logic             fib_fb;

    always_comb begin
        fib_fb      = ^(state & TAPS);
        galois_poly = {TAPS[WIDTH-2:0], 1'b1};
        if (mode) begin
            nxt = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? galois_poly : '0);
        end else begin
            nxt = {state[WIDTH-2:0], fib_fb};
        end
        cnt_inc  = cnt + WIDTH'(1);
        // An all-zero seed would lock the register up forever
        load_val = (seed_in == '0) ? WIDTH'(1) : seed_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEED;
            anchor      <= SEED;
            cnt         <= '0;
            period_done <= 1'b0;
            period_len  <= '0;
        end else if (load) begin
            state       <= load_val;
            anchor      <= load_val;
            cnt         <= '0;
            period_done <= 1'b0;
        end else if (en) begin
            state <= nxt;
            if (nxt == anchor) begin
                period_done <= 1'b1;
                period_len  <= cnt_inc;
                cnt         <= '0;
            end else begin
                period_done <= 1'b0;
                cnt         <= cnt_inc;
            end
        end else begin
            period_done <= 1'b0;
        end
    end

    assign data_out = state;
    assign bit_out  = state[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen against a polynomial-arithmetic model
module tb_lfsr_gen;

    localparam int         W    = 7;
    localparam logic [6:0] TAPS = 7'h60;
    localparam logic [6:0] SEED = 7'h01;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic         mode = 1'b0;
    logic [W-1:0] data_out;
    logic         bit_out;
    logic         period_done;
    logic [W-1:0] period_len;

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    lfsr_gen #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .mode(mode),
        .data_out(data_out), .bit_out(bit_out), .period_done(period_done), .period_len(period_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Step as multiplication by x: Fibonacci appends the tap parity, Galois reduces modulo the polynomial
    function automatic logic [W-1:0] model_next(input logic [W-1:0] s, input logic m);
        int v;
        int g;
        v = int'(s) * 2;
        if (!m) begin
            return W'(v | ($countones(s & TAPS) % 2));
        end
        g = ((int'(TAPS) << 1) & ((1 << W) - 1)) | 1;
        if (v >= (1 << W)) v = v ^ ((1 << W) | g);
        return W'(v);
    endfunction

    logic [W-1:0] m_state, m_anchor, m_len;
    logic         m_done;
    int           m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_state <= SEED; m_anchor <= SEED; m_cnt <= 0; m_done <= 1'b0; m_len <= '0;
        end else if (load) begin
            m_state  <= (seed_in == 0) ? W'(1) : seed_in;
            m_anchor <= (seed_in == 0) ? W'(1) : seed_in;
            m_cnt    <= 0;
            m_done   <= 1'b0;
        end else if (en) begin
            m_state <= model_next(m_state, mode);
            if (model_next(m_state, mode) == m_anchor) begin
                m_done <= 1'b1;
                m_len  <= W'((m_cnt + 1) % (1 << W));
                m_cnt  <= 0;
            end else begin
                m_done <= 1'b0;
                m_cnt  <= (m_cnt + 1) % (1 << W);
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_data", 32'(data_out), 32'(m_state));
            check("model_bit", 32'(bit_out), 32'(m_state[W-1]));
            check("model_done", 32'(period_done), 32'(m_done));
            check("model_len", 32'(period_len), 32'(m_len));
        end
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        armed = 1'b1;
        rst = 1'b0;
    endtask

    logic [6:0] fib_seq [0:8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03, 7'h06};
    logic [6:0] gal_seq [0:8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h41, 7'h43};

    initial begin
        bit seen [0:127];
        int first_pd;
        int bad;

        // Fibonacci from reset: literal prefix, period and distinctness
        mode = 1'b0;
        do_reset();
        check("reset_data", 32'(data_out), 32'h01);
        check("reset_bit", 32'(bit_out), 32'h0);
        check("reset_done", 32'(period_done), 32'h0);
        check("reset_len", 32'(period_len), 32'h0);
        foreach (seen[k]) seen[k] = 1'b0;
        seen[data_out] = 1'b1;
        first_pd = -1; bad = 0;
        en = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i <= 8) check("fib_seq", 32'(data_out), 32'(fib_seq[i]));
            if (period_done && first_pd < 0) begin
                first_pd = i;
                check("fib_wrap_data", 32'(data_out), 32'h01);
                check("fib_wrap_len", 32'(period_len), 32'd127);
            end
            if (first_pd < 0) begin
                if (data_out == '0 || seen[data_out]) bad++;
                seen[data_out] = 1'b1;
            end
        end
        check("fib_period", 32'(first_pd), 32'd127);
        check("fib_distinct", 32'(bad), 32'd0);

        // Galois from reset
        mode = 1'b1;
        do_reset();
        en = 1'b1;
        first_pd = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i <= 8) check("gal_seq", 32'(data_out), 32'(gal_seq[i]));
            if (period_done && first_pd < 0) begin
                first_pd = i;
                check("gal_wrap_data", 32'(data_out), 32'h01);
                check("gal_wrap_len", 32'(period_len), 32'd127);
            end
        end
        check("gal_period", 32'(first_pd), 32'd127);

        // Seed loading: zero protection, load beats en, then mode flips mid-run
        en = 1'b0; load = 1'b1; seed_in = '0;
        @(negedge clk);
        check("load_zero", 32'(data_out), 32'h01);
        en = 1'b1; seed_in = 7'h5A;
        @(negedge clk);
        check("load_with_en", 32'(data_out), 32'h5A);
        check("load_done", 32'(period_done), 32'h0);
        load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mode = i[1];
            @(negedge clk);
        end

        // en every other cycle: 127 steps take 254 cycles
        mode = 1'b0;
        do_reset();
        first_pd = -1;
        for (int c = 1; c <= 600 && first_pd < 0; c++) begin
            en = (c % 2 == 0);
            @(negedge clk);
            if (period_done) first_pd = c;
        end
        check("toggle_period_cycles", 32'(first_pd), 32'd254);
        check("toggle_len", 32'(period_len), 32'd127);

        // rst mid-sequence discards progress and the reported length
        en = 1'b1;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data", 32'(data_out), 32'h01);
        check("midrst_len", 32'(period_len), 32'h0);
        check("midrst_done", 32'(period_done), 32'h0);
        rst = 1'b0;
        first_pd = -1;
        for (int i = 1; i <= 300 && first_pd < 0; i++) begin
            @(negedge clk);
            if (period_done) first_pd = i;
        end
        check("midrst_period", 32'(first_pd), 32'd127);

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random sequence generator that generalises the team's fixed 7-bit shift-register LFSR. It has configurable width, feedback polynomial and seed, and selects Fibonacci or Galois form at run time. It also supports synchronous seed loading with zero-lockup protection, and measures the sequence period in hardware. It sits beside the lab FSMs as the random-delay and test-pattern source, and steps only when its enable is asserted, typically from a clock-divider tick.

## Interface
- WIDTH, 7, register width in bits; legal range 3..32.
- TAPS, 7'h60, Fibonacci tap mask; bit i set means polynomial term x^(i+1). Bit WIDTH-1 must be set. The default gives x^7+x^6+1.
- SEED, 7'h01, reset value of the state; must be nonzero.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  advance the state by one step this cycle.
- load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  value to load.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled on every step.
- data_out  out  WIDTH  current state, driven directly from the state register.
- bit_out  out  1  data_out[WIDTH-1].
- period_done  out  1  one-cycle pulse when the state returns to the anchor.
- period_len  out  WIDTH  step count of the last completed period; holds its value until the next period completes.

## Operation
- Priority per cycle: rst > load > en > hold.
- rst:
  - state = SEED; anchor = SEED.
  - step counter = 0; period_done = 0; period_len = 0.
- load:
  - state = seed_in, or 1 if seed_in == 0 (zero-lockup protection).
  - anchor = the value actually loaded.
  - step counter = 0; period_done = 0.
  - en asserted in the same cycle is ignored.
- Fibonacci step: fb = XOR-reduce(state & TAPS); state <= {state[WIDTH-2:0], fb}.
- Galois step:
  - G = {TAPS[WIDTH-2:0], 1'b1}.
  - state <= {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? G : 0).
- Both forms are maximal-length (period 2^WIDTH-1) for a primitive TAPS, but they produce different sequences.
- On each en step:
  - The step counter increments.
  - If the next state equals the anchor, then in that same edge:
    - period_done = 1 in the following cycle.
    - period_len = counter + 1.
    - counter = 0.
- The step counter is WIDTH bits wide. If it would wrap without a match (possible only for a non-primitive TAPS or a mid-run mode change), it rolls to 0 silently and period_len is not updated.
- The state can never reach zero: seeds are forced nonzero and both step functions are nonsingular.
- Changing mode mid-sequence takes effect on the next step. The anchor is not modified.
- With en low, state, counter and period_len all hold; period_done = 0.

## Timing
- Every output is registered; there is no combinational path from input to output.
- Latency: data_out shows the effect of load or en one cycle after the edge that samples it.
- period_done is high for exactly one cycle, coinciding with data_out == anchor after the wrap.
- With en held continuously on the default configuration, period_done recurs every 127 cycles.
- Reset values: data_out = SEED, bit_out = SEED[WIDTH-1], period_done = 0, period_len = 0.
- rst mid-sequence discards all progress with no partial period report. The same applies to load mid-sequence.

## Test plan
- Reset, default parameters, mode = 0, en = 1 -> data_out sequence 01, 02, 04, 08, 10, 20, 41, 03, 06.
- Continuous en in mode 0 from reset -> first period_done pulse 127 steps later, data_out = 01, period_len = 127. Check that all 127 intermediate values are distinct and nonzero.
- Mode = 1 from reset -> sequence 01, 02, 04, 08, 10, 20, 40, 41, 43. Period 127, period_len = 127.
- load = 1 with seed_in = 0 -> data_out = 01 next cycle. Assert load and en together with seed_in = 5A -> data_out = 5A (no step applied).
- en toggling 1/0 every other cycle -> data_out changes only after en cycles. period_done arrives after 127 en steps, i.e. 254 cycles.
- Assert rst mid-sequence (e.g. after step 60) -> data_out = 01, period_len = 0, no period_done pulse. Next wrap occurs 127 steps after reset.
